ofs_plat_shim_ccip_c0_rd_arb: RTL and testbench
===============================================

Name: ofs_plat_shim_ccip_c0_rd_arb

Overview:
- Shares one CCI-P c0 read-request channel among N_REQ independent requesters.
- Round-robin arbitration, gated by c0 almost-full and by tag availability.
- Rewrites mdata to an internal tag, restores the original mdata on each response, and steers the response to the owning requester.
- Sits between AFU-side engines and the FIU-side CCI-P chain (registers, sorting, clock crossing).

Parameters:
- N_REQ, 4: number of requesters (2..8).
- MAX_ACTIVE, 64: outstanding-read tags; power of 2, 2..512.
- TAG_W, $clog2(MAX_ACTIVE): derived; do not override.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester read request valid.
- req_ready  out  N_REQ  grant; request accepted when valid&ready.
- req_addr  in  N_REQ*42  per-requester line address.
- req_mdata  in  N_REQ*16  per-requester mdata.
- c0_tx_valid  out  1  read request to FIU.
- c0_tx_addr  out  42  line address to FIU.
- c0_tx_mdata  out  16  {zero pad, tag[TAG_W-1:0]}.
- c0_tx_almfull  in  1  FIU c0 almost full.
- c0_rx_valid  in  1  read response valid (no backpressure).
- c0_rx_mdata  in  16  response mdata; tag in low TAG_W bits.
- c0_rx_data  in  512  response data.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_mdata  out  16  restored original mdata.
- rsp_data  out  512  response data.
- idle  out  1  RUN state and zero tags outstanding.
- tag_error  out  1  sticky: response to an unallocated tag.

Behaviour:
- Scope is single-line reads only (cl_len=0). Exactly one response per request.
- States: INIT, RUN.
- Reset: state=INIT, init counter=0, free count=0, RR pointer=0, all outputs 0.
- INIT: pushes tag = init counter into the free-list FIFO, one per cycle, for MAX_ACTIVE cycles. Then moves to RUN. req_ready is 0 throughout INIT.
- RUN, grant condition: c0_tx_almfull==0 and free list non-empty. When true, grant the first valid requester at or after the RR pointer, wrapping modulo N_REQ.
- req_ready is one-hot and combinational from req_valid, the RR pointer and the gating conditions.
- On accept:
  - pop a tag from the free list;
  - write table[tag] = {requester index, req_mdata};
  - set the tag's busy bit;
  - RR pointer <= granted index+1 (mod N_REQ).
- c0_tx_valid/addr/mdata are registered: asserted the cycle after accept, for exactly 1 cycle. At most 1 request issues after almfull rises.
- On a response with c0_rx_valid:
  - cycle 1: register valid, tag and data;
  - cycle 2: look up table[tag]; drive rsp_valid[index]=1, rsp_mdata, rsp_data; clear busy; push tag to the free list.
  - Latency is 2 cycles from c0_rx_valid to rsp_valid; one response per cycle sustained.
- Simultaneous pop (accept) and push (response free) in one cycle: both occur; free count is unchanged.
- Free list empty: no grants until a tag is returned. A tag pushed in cycle t is grantable in cycle t+1.
- Response with busy[tag]==0:
  - rsp_valid stays 0;
  - tag_error sets and holds until reset;
  - free list is untouched.
- Responses are unordered. Routing is purely by tag.
- idle = RUN & (free count == MAX_ACTIVE) & no response in the pipeline.
- Reset mid-operation: all state returns to INIT. Responses in flight are discarded, and tags are reinitialised over MAX_ACTIVE cycles.
- Free count width is TAG_W+1 and never exceeds MAX_ACTIVE.

Test Plan:
- Reset, then hold all req_valid=1 -> req_ready=0 for exactly MAX_ACTIVE (64) cycles after reset release; first grant goes to requester 0 on cycle 65.
- All 4 requesters valid continuously, almfull=0, responses return immediately -> grants cycle 0,1,2,3,0,…; each requester receives 25% of 400 requests; every rsp_mdata equals the issued req_mdata.
- MAX_ACTIVE=4, no responses -> exactly 4 c0_tx_valid pulses, then req_ready=0. Return tag 2 -> exactly one new grant, whose c0_tx_mdata[1:0]=2.
- Raise almfull in the cycle of a grant -> that one registered request still issues; zero further c0_tx_valid while almfull=1; issue resumes the cycle after almfull falls.
- Requester 1 sends mdata 0xBEEF at addr 0x100; response returns tag out of order behind other traffic -> rsp_valid=4'b0010 and rsp_mdata=0xBEEF, 2 cycles after c0_rx_valid.
- Inject c0_rx_valid with a never-issued tag -> no rsp_valid and tag_error=1 persistently. Then assert reset_n=0 for 1 cycle mid-traffic -> tag_error=0, idle=1 after 64 init cycles.

Source files
------------

// File: rtl/ofs_plat_shim_ccip_c0_rd_arb.sv
// CCI-P c0 read-request arbiter: shares one c0 read channel among N_REQ
// requesters. Requests are granted round-robin when the FIU is not almost
// full and a tag is free. The requester's mdata is replaced with an internal
// tag on the way out. On the way back, the tag finds the owner and the
// original mdata.
module ofs_plat_shim_ccip_c0_rd_arb #(
    parameter int N_REQ      = 4,
    parameter int MAX_ACTIVE = 64,
    parameter int TAG_W      = $clog2(MAX_ACTIVE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*42-1:0] req_addr,
    input  logic [N_REQ*16-1:0] req_mdata,
    output logic                c0_tx_valid,
    output logic [41:0]         c0_tx_addr,
    output logic [15:0]         c0_tx_mdata,
    input  logic                c0_tx_almfull,
    input  logic                c0_rx_valid,
    input  logic [15:0]         c0_rx_mdata,
    input  logic [511:0]        c0_rx_data,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [15:0]         rsp_mdata,
    output logic [511:0]        rsp_data,
    output logic                idle,
    output logic                tag_error
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_ACTIVE);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(MAX_ACTIVE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Requester index -> one-hot strobe vector
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == idx) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    state_t             state_r, state_nx_s;
    logic [TAG_W-1:0]   init_cnt_r;

    // Free-tag FIFO; pointers wrap naturally since MAX_ACTIVE is a power of 2
    logic [TAG_W-1:0]   fl_mem_r [MAX_ACTIVE];
    logic [TAG_W-1:0]   fl_rd_r, fl_wr_r;
    logic [CNT_W-1:0]   free_cnt_r, free_cnt_nx_s;

    // Per-tag owner table and outstanding flags
    logic [IDX_W-1:0]   tbl_idx_r   [MAX_ACTIVE];
    logic [15:0]        tbl_mdata_r [MAX_ACTIVE];
    logic [MAX_ACTIVE-1:0] busy_r;

    logic [IDX_W-1:0]   rr_r;

    // First response pipeline stage
    logic               rx_valid_r;
    logic [TAG_W-1:0]   rx_tag_r;
    logic [511:0]       rx_data_r;

    logic               hi_hit_s, lo_hit_s, grant_any_s, grant_en_s, accept_s;
    logic [IDX_W-1:0]   hi_idx_s, lo_idx_s, grant_idx_s;
    logic [TAG_W-1:0]   pop_tag_s, push_tag_s;
    logic               push_s, rsp_hit_s, rx_cap_s;
    logic               unused_s;

    // Only the tag bits of the returned mdata carry meaning
    assign unused_s = ^c0_rx_mdata[15:TAG_W];

    // Round-robin search: the lowest valid index at/after rr_r wins, else the lowest below it
    always_comb begin
        hi_hit_s = 1'b0;
        hi_idx_s = '0;
        lo_hit_s = 1'b0;
        lo_idx_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (IDX_W'(i) >= rr_r)) begin
                hi_hit_s = 1'b1;
                hi_idx_s = IDX_W'(i);
            end else if (req_valid[i]) begin
                lo_hit_s = 1'b1;
                lo_idx_s = IDX_W'(i);
            end else begin
                hi_hit_s = hi_hit_s;
            end
        end
    end

    // Grant gating, accept strobe and free-list/response bookkeeping signals
    always_comb begin
        grant_any_s = hi_hit_s | lo_hit_s;
        grant_idx_s = hi_hit_s ? hi_idx_s : lo_idx_s;
        grant_en_s  = (state_r == ST_RUN) && !c0_tx_almfull && (free_cnt_r != '0);
        accept_s    = grant_en_s && grant_any_s;
        if (accept_s) begin
            req_ready = idx_onehot(grant_idx_s);
        end else begin
            req_ready = '0;
        end
        pop_tag_s  = fl_mem_r[fl_rd_r];
        rsp_hit_s  = rx_valid_r && busy_r[rx_tag_r];
        rx_cap_s   = c0_rx_valid && (state_r == ST_RUN);
        push_s     = (state_r == ST_INIT) || rsp_hit_s;
        if (state_r == ST_INIT) begin
            push_tag_s = init_cnt_r;
        end else begin
            push_tag_s = rx_tag_r;
        end
    end

    // Next free count: a simultaneous push and pop leave it unchanged
    always_comb begin
        free_cnt_nx_s = free_cnt_r;
        case ({push_s, accept_s})
            2'b10:   free_cnt_nx_s = free_cnt_r + CNT_W'(1);
            2'b01:   free_cnt_nx_s = free_cnt_r - CNT_W'(1);
            default: free_cnt_nx_s = free_cnt_r;
        endcase
    end

    // Next state: INIT seeds every tag once, then RUN forever
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_TAG) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_RUN:  state_nx_s = ST_RUN;
            default: state_nx_s = ST_INIT;
        endcase
    end

    // Control state, request issue, response pipeline and status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= '0;
            fl_rd_r     <= '0;
            fl_wr_r     <= '0;
            free_cnt_r  <= '0;
            rr_r        <= '0;
            busy_r      <= '0;
            rx_valid_r  <= 1'b0;
            rx_tag_r    <= '0;
            rx_data_r   <= '0;
            c0_tx_valid <= 1'b0;
            c0_tx_addr  <= '0;
            c0_tx_mdata <= '0;
            rsp_valid   <= '0;
            rsp_mdata   <= '0;
            rsp_data    <= '0;
            idle        <= 1'b0;
            tag_error   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            free_cnt_r <= free_cnt_nx_s;
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + TAG_W'(1);
            end
            if (push_s) begin
                fl_wr_r <= fl_wr_r + TAG_W'(1);
            end
            if (accept_s) begin
                fl_rd_r         <= fl_rd_r + TAG_W'(1);
                rr_r            <= (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
                busy_r[pop_tag_s] <= 1'b1;
                c0_tx_addr      <= req_addr[int'(grant_idx_s)*42 +: 42];
                c0_tx_mdata     <= {{(16-TAG_W){1'b0}}, pop_tag_s};
            end
            c0_tx_valid <= accept_s;

            rx_valid_r <= rx_cap_s;
            rx_tag_r   <= c0_rx_mdata[TAG_W-1:0];
            rx_data_r  <= c0_rx_data;

            if (rsp_hit_s) begin
                busy_r[rx_tag_r] <= 1'b0;
                rsp_valid        <= idx_onehot(tbl_idx_r[rx_tag_r]);
                rsp_mdata        <= tbl_mdata_r[rx_tag_r];
                rsp_data         <= rx_data_r;
            end else begin
                rsp_valid <= '0;
            end
            tag_error <= tag_error | (rx_valid_r & ~busy_r[rx_tag_r]);
            idle      <= (state_nx_s == ST_RUN) && (free_cnt_nx_s == FULL_CNT) && !rx_cap_s;
        end
    end

    // Free-list storage and tag owner table (contents are don't-care until written)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fl_mem_r[fl_wr_r] <= push_tag_s;
        end
        if (accept_s) begin
            tbl_idx_r[pop_tag_s]   <= grant_idx_s;
            tbl_mdata_r[pop_tag_s] <= req_mdata[int'(grant_idx_s)*16 +: 16];
        end
    end

endmodule

// File: tb/tb_ofs_plat_shim_ccip_c0_rd_arb.sv
// Scoreboard bench for the c0 read arbiter: a high-level model predicts the
// grant each cycle. Issued requests and returned responses are queued and
// checked by an independent negedge monitor.
module tb_ofs_plat_shim_ccip_c0_rd_arb;
    localparam int N  = 4;
    localparam int MA = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*42-1:0] req_addr;
    logic [N*16-1:0] req_mdata;
    logic           c0_tx_valid;
    logic [41:0]    c0_tx_addr;
    logic [15:0]    c0_tx_mdata;
    logic           c0_tx_almfull;
    logic           c0_rx_valid;
    logic [15:0]    c0_rx_mdata;
    logic [511:0]   c0_rx_data;
    logic [N-1:0]   rsp_valid;
    logic [15:0]    rsp_mdata;
    logic [511:0]   rsp_data;
    logic           idle, tag_error;

    ofs_plat_shim_ccip_c0_rd_arb #(.N_REQ(N), .MAX_ACTIVE(MA)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_mdata(req_mdata),
        .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr), .c0_tx_mdata(c0_tx_mdata),
        .c0_tx_almfull(c0_tx_almfull),
        .c0_rx_valid(c0_rx_valid), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .idle(idle), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int idx; logic [41:0] addr; logic [15:0] md; } tx_t;
    typedef struct { int due; int idx; logic [15:0] md; logic [511:0] data; } rsp_t;

    tx_t  txq[$];
    rsp_t rspq[$];
    int   pend[$];
    int   retq[$];
    int   exp_idx[MA];
    logic [15:0] exp_md[MA];
    bit   outst[MA];
    int   model_free, model_rr, run_cyc;
    int   acc_cnt[N];
    int   acc_total, tx_count;
    int   expect_tag = -1;
    logic [N-1:0] last_ready;
    int   tests = 0, fails = 0;
    tx_t  mon_tx;
    rsp_t mon_rsp;
    int   mon_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < N; i++) begin
            int k = (rr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic rand_req(input logic [N-1:0] v);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_addr[i*42 +: 42]  = {10'($urandom), $urandom};
            req_mdata[i*16 +: 16] = 16'($urandom);
        end
    endtask

    task automatic send_rsp(input int pi);
        int t;
        rsp_t r;
        t = pend[pi];
        pend.delete(pi);
        c0_rx_valid = 1'b1;
        c0_rx_mdata = {10'($urandom), 6'(t)};
        c0_rx_data  = rand512();
        r.due  = cyc + 2;
        r.idx  = exp_idx[t];
        r.md   = exp_md[t];
        r.data = c0_rx_data;
        rspq.push_back(r);
        retq.push_back(cyc + 2);
        outst[t] = 1'b0;
    endtask

    // One clock: predict and check the grant, record it, then advance
    task automatic tick();
        int g;
        tx_t e;
        logic [63:0] expv;
        #1;
        if (cyc >= run_cyc && !c0_tx_almfull && model_free > 0) g = pick(req_valid, model_rr);
        else g = -1;
        expv = (g < 0) ? 64'd0 : (64'd1 << g);
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), expv);
        if (g >= 0) begin
            e.due  = cyc + 1;
            e.idx  = g;
            e.addr = req_addr[g*42 +: 42];
            e.md   = req_mdata[g*16 +: 16];
            txq.push_back(e);
            model_free--;
            model_rr = (g + 1) % N;
            acc_cnt[g]++;
            acc_total++;
        end
        @(posedge clk);
        #1;
        c0_rx_valid = 1'b0;
        while (retq.size() > 0 && retq[0] <= cyc) begin
            void'(retq.pop_front());
            model_free++;
        end
    endtask

    task automatic do_reset(input int n);
        req_valid = '0;
        c0_rx_valid = 1'b0;
        c0_tx_almfull = 1'b0;
        reset_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
        txq.delete(); rspq.delete(); pend.delete(); retq.delete();
        for (int i = 0; i < MA; i++) outst[i] = 1'b0;
        model_free = MA;
        model_rr = 0;
        run_cyc = cyc + MA;
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        c0_tx_almfull = 1'b0;
        for (n = 0; n < 1000; n++) begin
            if (pend.size() == 0 && txq.size() == 0 && rspq.size() == 0 && retq.size() == 0) break;
            if (pend.size() > 0) send_rsp($urandom_range(0, pend.size() - 1));
            tick();
        end
        if (n >= 1000) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", pend.size() + txq.size());
        end
        repeat (3) tick();
    endtask

    // Monitor: match every issued request and every response against the queues
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (c0_tx_valid) begin
                if (txq.size() == 0 || txq[0].due != cyc) begin
                    tests++; fails++;
                    $display("FAIL tx_unexpected: got tx_valid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_tx  = txq.pop_front();
                    mon_tag = int'(c0_tx_mdata[5:0]);
                    chk("tx_addr", 64'(c0_tx_addr), 64'(mon_tx.addr));
                    chk("tx_mdata_pad", 64'(c0_tx_mdata[15:6]), 64'd0);
                    chk("tx_tag_not_busy", 64'(outst[mon_tag]), 64'd0);
                    if (expect_tag >= 0) begin
                        chk("tx_returned_tag", 64'(mon_tag), 64'(expect_tag));
                        expect_tag = -1;
                    end
                    outst[mon_tag]   = 1'b1;
                    exp_idx[mon_tag] = mon_tx.idx;
                    exp_md[mon_tag]  = mon_tx.md;
                    pend.push_back(mon_tag);
                    tx_count++;
                end
            end else if (txq.size() > 0 && txq[0].due == cyc) begin
                void'(txq.pop_front());
                tests++; fails++;
                $display("FAIL tx_missing: got tx_valid=0 expected 1 (cycle %0d)", cyc);
            end
            if (rsp_valid != '0) begin
                if (rspq.size() == 0 || rspq[0].due != cyc) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got rsp_valid=0x%0h expected 0 (cycle %0d)", rsp_valid, cyc);
                end else begin
                    mon_rsp = rspq.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'd1 << mon_rsp.idx);
                    chk("rsp_mdata", 64'(rsp_mdata), 64'(mon_rsp.md));
                    chk("rsp_data_lo", rsp_data[63:0], mon_rsp.data[63:0]);
                    chk("rsp_data_hi", rsp_data[511:448], mon_rsp.data[511:448]);
                end
            end else if (rspq.size() > 0 && rspq[0].due == cyc) begin
                void'(rspq.pop_front());
                tests++; fails++;
                $display("FAIL rsp_missing: got rsp_valid=0 expected strobe (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int zero_cnt;
        bit first_seen;
        logic [N-1:0] first_ready;
        int t;

        reset_n = 1'b0;
        req_valid = '0; req_addr = '0; req_mdata = '0;
        c0_tx_almfull = 1'b0; c0_rx_valid = 1'b0; c0_rx_mdata = '0; c0_rx_data = '0;
        model_free = 0; model_rr = 0; run_cyc = 1 << 30;
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_tx_valid", 64'(c0_tx_valid), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_tag_error", 64'(tag_error), 64'd0);

        // Init window then saturated round robin with immediate responses
        zero_cnt = 0; first_seen = 1'b0; first_ready = '0; acc_total = 0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        for (int n = 0; n < 1200 && acc_total < 400; n++) begin
            rand_req(4'hF);
            c0_tx_almfull = 1'b0;
            if (pend.size() > 0) send_rsp(0);
            if (cyc == run_cyc - 1) chk("idle_during_init", 64'(idle), 64'd0);
            if (cyc == run_cyc)     chk("idle_after_init", 64'(idle), 64'd1);
            tick();
            if (!first_seen) begin
                if (last_ready == '0) zero_cnt++;
                else begin first_seen = 1'b1; first_ready = last_ready; end
            end
        end
        chk("init_ready_low_cycles", 64'(zero_cnt), 64'd64);
        chk("first_grant", 64'(first_ready), 64'd1);
        chk("rr_total", 64'(acc_total), 64'd400);
        for (int i = 0; i < N; i++) chk("rr_share", 64'(acc_cnt[i]), 64'd100);
        drain();

        // Directed: requester 1, mdata BEEF, then random traffic with almfull
        rand_req(4'b0010);
        req_addr[42 +: 42]  = 42'h100;
        req_mdata[16 +: 16] = 16'hBEEF;
        tick();
        for (int n = 0; n < 600; n++) begin
            rand_req(4'($urandom));
            c0_tx_almfull = ($urandom_range(0, 3) == 0);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) send_rsp($urandom_range(0, pend.size() - 1));
            tick();
        end
        drain();
        chk("idle_after_random", 64'(idle), 64'd1);
        chk("tag_error_clean", 64'(tag_error), 64'd0);

        // Free-list exhaustion, then a single returned tag
        tx_count = 0; acc_total = 0;
        for (int n = 0; n < 80; n++) begin
            rand_req(4'hF);
            tick();
        end
        chk("exhaust_tx_count", 64'(tx_count), 64'd64);
        chk("exhaust_ready", 64'(last_ready), 64'd0);
        expect_tag = pend[2];
        rand_req(4'hF);
        send_rsp(2);
        tick();
        for (int n = 0; n < 7; n++) begin
            rand_req(4'hF);
            tick();
        end
        chk("exhaust_regrant", 64'(acc_total), 64'd65);
        chk("exhaust_tx_after", 64'(tx_count), 64'd65);
        chk("returned_tag_seen", 64'(expect_tag + 1), 64'd0);
        drain();

        // Response to a tag nobody owns
        t = 5;
        req_valid = '0;
        c0_rx_valid = 1'b1;
        c0_rx_mdata = 16'(t);
        c0_rx_data  = rand512();
        tick();
        chk("tag_error_not_yet", 64'(tag_error), 64'd0);
        tick();
        for (int n = 0; n < 5; n++) begin
            chk("tag_error_sticky", 64'(tag_error), 64'd1);
            tick();
        end
        chk("idle_after_bad_tag", 64'(idle), 64'd1);

        // Reset in the middle of traffic with tags outstanding
        for (int n = 0; n < 10; n++) begin
            rand_req(4'hF);
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
        do_reset(1);
        chk("tag_error_cleared", 64'(tag_error), 64'd0);
        for (int n = 0; n < 80; n++) begin
            rand_req(4'hF);
            if (pend.size() > 0) send_rsp(0);
            if (cyc == run_cyc - 1) chk("idle_during_reinit", 64'(idle), 64'd0);
            if (cyc == run_cyc)     chk("idle_after_reinit", 64'(idle), 64'd1);
            tick();
        end
        drain();
        chk("idle_final", 64'(idle), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
